// File: rtl/led_pattern_gen.sv
// led_pattern_gen
//   Multi-channel LED driver. Each of N_CH channels is independently OFF,
//   ON, BLINK (global slow square wave) or PWM (per-channel duty against a
//   shared free-running counter). Channel configuration arrives over a
//   simple one-channel-per-cycle write port.
//
// Ports
//   clk      in   1      clock, all logic on posedge
//   reset    in   1      synchronous, active-high
//   wr_en    in   1      config write strobe
//   wr_ch    in   CH_W   target channel, values >= N_CH are ignored
//   wr_mode  in   2      0=OFF 1=ON 2=BLINK 3=PWM
//   wr_duty  in   PWM_W  PWM duty, stored regardless of mode
//   led      out  N_CH   registered LED drive, active-high
//   tick     out  1      registered prescaler tick, one clk wide

module led_pattern_gen #(
    parameter int N_CH        = 3,
    parameter int TICK_CYCLES = 1000,
    parameter int BLINK_TICKS = 1000,
    parameter int PWM_W       = 8,
    localparam int CH_W       = (N_CH > 1) ? $clog2(N_CH) : 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             wr_en,
    input  logic [CH_W-1:0]  wr_ch,
    input  logic [1:0]       wr_mode,
    input  logic [PWM_W-1:0] wr_duty,
    output logic [N_CH-1:0]  led,
    output logic             tick
);

    typedef enum logic [1:0] {
        MODE_OFF   = 2'd0,
        MODE_ON    = 2'd1,
        MODE_BLINK = 2'd2,
        MODE_PWM   = 2'd3
    } mode_t;

    localparam int PRESC_W = ($clog2(TICK_CYCLES + 1) > 0) ? $clog2(TICK_CYCLES + 1) : 1;
    localparam int BCNT_W  = ($clog2(BLINK_TICKS + 1) > 0) ? $clog2(BLINK_TICKS + 1) : 1;

    localparam logic [PRESC_W-1:0] PRESC_LAST = PRESC_W'(TICK_CYCLES - 1);
    localparam logic [BCNT_W-1:0]  BCNT_LAST  = BCNT_W'(BLINK_TICKS - 1);
    // One extra bit so N_CH itself is representable when it is a power of two.
    localparam logic [CH_W:0]      N_CH_L     = (CH_W + 1)'(N_CH);

    logic [PRESC_W-1:0] presc;
    logic [BCNT_W-1:0]  bcnt;
    logic               blink_ph;
    logic [PWM_W-1:0]   pwm_cnt;
    mode_t              mode [N_CH];
    logic [PWM_W-1:0]   duty [N_CH];

    logic               tick_int;
    logic               wr_hit;
    logic [N_CH-1:0]    led_next;

    assign tick_int = (presc == PRESC_LAST);
    assign wr_hit   = wr_en && ({1'b0, wr_ch} < N_CH_L);

    // Timebase: prescaler, blink phase and PWM counter run independently of
    // any configuration traffic.
    always_ff @(posedge clk) begin
        if (reset) begin
            presc    <= '0;
            bcnt     <= '0;
            blink_ph <= 1'b0;
            pwm_cnt  <= '0;
            tick     <= 1'b0;
        end else begin
            tick    <= tick_int;
            pwm_cnt <= pwm_cnt + PWM_W'(1);
            if (tick_int) begin
                presc <= '0;
                if (bcnt == BCNT_LAST) begin
                    bcnt     <= '0;
                    blink_ph <= ~blink_ph;
                end else begin
                    bcnt <= bcnt + BCNT_W'(1);
                end
            end else begin
                presc <= presc + PRESC_W'(1);
            end
        end
    end

    // Per-channel configuration; only the addressed channel changes.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < N_CH; i++) begin
                mode[i] <= MODE_OFF;
                duty[i] <= '0;
            end
        end else if (wr_hit) begin
            mode[wr_ch] <= mode_t'(wr_mode);
            duty[wr_ch] <= wr_duty;
        end
    end

    always_comb begin
        led_next = '0;
        for (int i = 0; i < N_CH; i++) begin
            case (mode[i])
                MODE_OFF:   led_next[i] = 1'b0;
                MODE_ON:    led_next[i] = 1'b1;
                MODE_BLINK: led_next[i] = blink_ph;
                MODE_PWM:   led_next[i] = (pwm_cnt < duty[i]);
                default:    led_next[i] = 1'b0;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            led <= '0;
        end else begin
            led <= led_next;
        end
    end

endmodule
